// File: rtl/stim_pulse_gen.sv
// Multi-channel stimulation pulse generator: monophasic or charge-balanced biphasic
// pulse trains with programmable width, period and burst length; all outputs registered.
module stim_pulse_gen #(
    parameter int N_CH    = 4,
    parameter int CNT_W   = 16,
    parameter int BURST_W = 8,
    parameter int IPG     = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic [N_CH-1:0]    ch_mask,
    input  logic               rr_mode,
    input  logic               biphasic,
    input  logic [CNT_W-1:0]   pulse_width,
    input  logic [CNT_W-1:0]   period,
    input  logic [BURST_W-1:0] burst_len,
    output logic [N_CH-1:0]    stim_pos,
    output logic [N_CH-1:0]    stim_neg,
    output logic               busy,
    output logic               done
);
    // Period arithmetic needs headroom for 2*pw+IPG on top of CNT_W.
    localparam int AW    = CNT_W + 2;
    localparam int PTR_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    typedef enum logic [2:0] {IDLE, PH_A, GAP, PH_B, REST} state_t;

    state_t             state_q, state_d;
    logic [N_CH-1:0]    mask_q, mask_d, act_q, act_d;
    logic               rr_q, rr_d, bi_q, bi_d, stop_pend_q, stop_pend_d;
    logic [CNT_W-1:0]   pw_q, pw_d, period_q, period_d;
    logic [BURST_W-1:0] burst_q, burst_d, pcnt_q, pcnt_d;
    logic [AW-1:0]      per_q, per_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [N_CH-1:0]    pos_q, pos_d, neg_q, neg_d;
    logic               busy_q, busy_d, done_q, done_d;

    logic [AW-1:0] pw_w, a_len, gap_end, per_ext, peff, per_inc;
    logic          end_act, pulse_end, go_idle, last_pulse;

    function automatic logic [PTR_W-1:0] find_ch(input logic [N_CH-1:0] m, input int base);
        logic [PTR_W-1:0] r;
        logic             found;
        int               idx;
        r     = '0;
        found = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            idx = (base + i) % N_CH;
            if (!found && ((m >> idx) & N_CH'(1)) != '0) begin
                r     = PTR_W'(idx);
                found = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic logic [N_CH-1:0] onehot(input logic [PTR_W-1:0] p);
        return N_CH'(1) << p;
    endfunction

    assign pw_w    = (pw_q == '0) ? AW'(1) : AW'(pw_q);
    assign gap_end = pw_w + AW'(IPG);
    assign a_len   = bi_q ? (pw_w + pw_w + AW'(IPG)) : pw_w;
    assign per_ext = AW'(period_q);
    assign peff    = (per_ext > a_len) ? per_ext : a_len;
    assign per_inc = (per_q == '1) ? per_q : per_q + AW'(1);
    assign last_pulse = (burst_q != '0) &&
                        (({1'b0, pcnt_q} + (BURST_W+1)'(1)) == {1'b0, burst_q});

    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        rr_d        = rr_q;
        bi_d        = bi_q;
        pw_d        = pw_q;
        period_d    = period_q;
        burst_d     = burst_q;
        pcnt_d      = pcnt_q;
        per_d       = per_q;
        ptr_d       = ptr_q;
        act_d       = act_q;
        stop_pend_d = stop_pend_q;
        done_d      = 1'b0;
        end_act     = 1'b0;
        pulse_end   = 1'b0;
        go_idle     = 1'b0;

        case (state_q)
            IDLE: begin
                // busy_q is still high during the done cycle, so a start there is dropped.
                if (start && (ch_mask != '0) && !busy_q) begin
                    mask_d      = ch_mask;
                    rr_d        = rr_mode;
                    bi_d        = biphasic;
                    pw_d        = pulse_width;
                    period_d    = period;
                    burst_d     = burst_len;
                    pcnt_d      = '0;
                    per_d       = AW'(1);
                    stop_pend_d = 1'b0;
                    ptr_d       = find_ch(ch_mask, 0);
                    act_d       = rr_mode ? onehot(ptr_d) : ch_mask;
                    state_d     = PH_A;
                end
            end
            PH_A: begin
                per_d       = per_inc;
                stop_pend_d = stop_pend_q | stop;
                if (per_q >= pw_w) begin
                    if (bi_q) state_d = (IPG > 0) ? GAP : PH_B;
                    else      end_act = 1'b1;
                end
            end
            GAP: begin
                per_d       = per_inc;
                stop_pend_d = stop_pend_q | stop;
                if (per_q >= gap_end) state_d = PH_B;
            end
            PH_B: begin
                per_d       = per_inc;
                stop_pend_d = stop_pend_q | stop;
                if (per_q >= a_len) end_act = 1'b1;
            end
            REST: begin
                per_d = per_inc;
                if (stop)               go_idle   = 1'b1;
                else if (per_q >= peff) pulse_end = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        // A stop seen anywhere in the active part skips REST but never truncates the pulse.
        if (end_act) begin
            if (stop_pend_q || stop) go_idle   = 1'b1;
            else if (a_len >= peff)  pulse_end = 1'b1;
            else                     state_d   = REST;
        end

        if (pulse_end) begin
            if (burst_q != '0) pcnt_d = (pcnt_q == '1) ? pcnt_q : pcnt_q + BURST_W'(1);
            if (last_pulse) begin
                go_idle = 1'b1;
            end else begin
                state_d = PH_A;
                per_d   = AW'(1);
                if (rr_q) begin
                    ptr_d = find_ch(mask_q, int'(ptr_q) + 1);
                    act_d = onehot(ptr_d);
                end
            end
        end

        if (go_idle) begin
            state_d = IDLE;
            done_d  = 1'b1;
        end

        pos_d  = (state_d == PH_A) ? act_d : '0;
        neg_d  = (state_d == PH_B) ? act_d : '0;
        busy_d = (state_d != IDLE) || done_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            mask_q      <= '0;
            rr_q        <= 1'b0;
            bi_q        <= 1'b0;
            pw_q        <= '0;
            period_q    <= '0;
            burst_q     <= '0;
            pcnt_q      <= '0;
            per_q       <= '0;
            ptr_q       <= '0;
            act_q       <= '0;
            stop_pend_q <= 1'b0;
            pos_q       <= '0;
            neg_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            rr_q        <= rr_d;
            bi_q        <= bi_d;
            pw_q        <= pw_d;
            period_q    <= period_d;
            burst_q     <= burst_d;
            pcnt_q      <= pcnt_d;
            per_q       <= per_d;
            ptr_q       <= ptr_d;
            act_q       <= act_d;
            stop_pend_q <= stop_pend_d;
            pos_q       <= pos_d;
            neg_q       <= neg_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign stim_pos = pos_q;
    assign stim_neg = neg_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: doc/stim_pulse_gen.md
Name: stim_pulse_gen

Overview:
- Parametrised multi-channel stimulation pulse generator; successor to the single-channel gated-clock divider stimulus.
- Produces registered monophasic or biphasic, charge-balanced pulse trains with programmable width, period and burst count.
- Supports simultaneous or round-robin channel delivery.
- Sits between the control/config logic and the electrode driver stage.

Parameters:
N_CH, 4, number of stimulation channels (1..16)
CNT_W, 16, width of pulse_width and period counters
BURST_W, 8, width of burst_len and pulse counter
IPG, 1, interphase gap in cycles between phase A and phase B (0 = no gap)

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous active-low reset
start  input  1  begin burst; sampled only in IDLE
stop  input  1  request termination (level, sampled every cycle)
ch_mask  input  N_CH  enabled channels; latched on start
rr_mode  input  1  0 = all enabled channels together, 1 = round-robin; latched on start
biphasic  input  1  1 = add phase B; latched on start
pulse_width  input  CNT_W  phase length in cycles; 0 treated as 1; latched on start
period  input  CNT_W  pulse-to-pulse period in cycles; latched on start
burst_len  input  BURST_W  pulses per burst; 0 = continuous until stop; latched on start
stim_pos  output  N_CH  phase A (cathodic) drive per channel
stim_neg  output  N_CH  phase B (anodic) drive per channel
busy  output  1  high in any state except IDLE
done  output  1  one-cycle pulse when a burst ends

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; stim_pos=0, stim_neg=0, busy=0, done=0; all counters and the round-robin pointer cleared. Release takes effect at the next clk edge.
- All outputs are registered. stim_pos[i] and stim_neg[i] are never both high.
- States: IDLE, PH_A, GAP, PH_B, REST.
- IDLE: start=1 with ch_mask!=0 latches the config. The following cycle is the first PH_A cycle. start with ch_mask=0 is ignored, and busy stays 0.
- PH_A: lasts pw=max(pulse_width,1) cycles. stim_pos = active channel set. The next state is GAP if biphasic and IPG>0, PH_B if biphasic and IPG=0, otherwise REST.
- GAP: lasts IPG cycles with all outputs 0, then PH_B.
- PH_B: lasts pw cycles. stim_neg = same channel set as the preceding PH_A.
- Period counter: restarts at 1 on each PH_A entry and increments every cycle.
- Effective period: Peff = max(period, active_len), where active_len = pw, or 2*pw+IPG when biphasic.
- REST: outputs 0 for Peff - active_len cycles; this may be zero cycles, in which case the next PH_A follows the last active cycle directly.
- After each pulse completes, the pulse counter increments. If burst_len!=0 and count==burst_len: done=1 for one cycle, then return to IDLE. Otherwise the next PH_A starts.
- Active channel set:
  - rr_mode=0: the latched ch_mask.
  - rr_mode=1: exactly one bit, the next enabled channel in ascending index, wrapping N_CH-1 -> 0.
  - The pointer starts at the lowest enabled channel on each start.
- stop in PH_A, GAP or PH_B: the current pulse completes in full, including PH_B, for charge balance. Then done=1 and the block goes to IDLE without REST.
- stop in REST: immediate transition to IDLE with done=1 in the same cycle as the transition.
- stop takes priority over start-of-next-pulse. start while busy is ignored.
- Config inputs may change while busy without effect.
- Counters saturate and never wrap within a phase. The pulse counter is unused when burst_len=0, so it does not overflow.
- done and busy:
  - done asserts only while busy=1.
  - busy falls in the cycle after done.
- Reset mid-pulse clears outputs immediately, asynchronously. This is the accepted exception to charge balance.

Test Plan:
- Monophasic, N_CH=4, ch_mask=4'b0101, rr_mode=0, pw=3, period=10, burst_len=2 -> stim_pos=0101 for 3 cycles starting 1 cycle after start, again 10 cycles later; done pulse after the second REST; stim_neg always 0.
- Biphasic, pw=2, IPG=1, period=4 (< active_len=5) -> pattern pos×2, gap×1, neg×2, repeating every 5 cycles with no REST.
- Round-robin, ch_mask=4'b1011, burst_len=4 -> per-pulse channel sequence 0,1,3,0.
- Continuous (burst_len=0), stop asserted during PH_A of pulse 3 -> pulse 3 finishes PH_B, done=1, IDLE; stop asserted during REST -> done in the next cycle.
- Edge cases: pulse_width=0 -> 1-cycle phases; start with ch_mask=0 -> busy stays 0; start while busy -> no effect.
- rst pulled low mid-PH_B -> stim_pos, stim_neg, busy and done go to 0 without waiting for clk; after release, a new start behaves normally.
